// File: rtl/cdce_spi_responder_pkg.sv
// Shared constants and helpers for the CDCE-style SPI register responder.
package cdce_resp_pkg;
  localparam int          FRAME_BITS  = 32;
  localparam int          DATA_BITS   = 28;
  localparam logic [5:0]  BIT_CNT_MAX = 6'd33;

  localparam logic [3:0]  ADDR_REG0  = 4'h0;
  localparam logic [3:0]  ADDR_REG1  = 4'h1;
  localparam logic [3:0]  ADDR_READ  = 4'h2;
  localparam logic [3:0]  ADDR_APPLY = 4'hF;

  localparam logic [DATA_BITS-1:0] REG0_RST = 28'h0000000;
  localparam logic [DATA_BITS-1:0] REG1_RST = 28'h8000000;
  localparam logic [1:0]           REG1_RO  = 2'b10;

  typedef enum logic [1:0] {
    ST_FLUSH,   // synchronisers settling after reset
    ST_IDLE,
    ST_FRAME,
    ST_IGNORE   // frame already open at reset release; swallow it
  } frame_state_t;

  // Register 1 carries a fixed pattern in its top two bits.
  function automatic logic [DATA_BITS-1:0] reg1_write(input logic [25:0] d);
    return {REG1_RO, d};
  endfunction
endpackage

// File: rtl/cdce_spi_responder_if.sv
// SPI bus between the initiator and the responder.
interface cdce_spi_responder_if;
  logic spi_clk;
  logic spi_le;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_le, output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_le, input spi_mosi, output spi_miso);
endinterface

// File: rtl/cdce_spi_responder_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= {STAGES{IDLE_VAL}};
      prev_reg <= IDLE_VAL;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;
endmodule

// File: rtl/cdce_spi_responder.sv
// SPI register responder: 32-bit LSB-first frames into shadow/applied registers.
// Readback over spi_miso is built only when CDCE_RESP_READBACK_EN is defined.
module cdce_spi_responder
  import cdce_resp_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  cdce_spi_responder_if.slave        spi,
  output logic [DATA_BITS-1:0]       shadow0,
  output logic [DATA_BITS-1:0]       shadow1,
  output logic [DATA_BITS-1:0]       cfg0,
  output logic [DATA_BITS-1:0]       cfg1,
  output logic                       cfg_update,
  output logic                       frame_ok,
  output logic                       frame_err,
  output logic                       in_frame
);
  // Bit order {mosi, le, clk}; LE idles high, SPI clock idles low.
  localparam logic [2:0] SYNC_IDLE = 3'b010;

  logic [2:0] sync_din, sync_level, sync_rise, sync_fall;
  assign sync_din = {spi.spi_mosi, spi.spi_le, spi.spi_clk};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(SYNC_IDLE[gi])) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync_din[gi]),
      .level   (sync_level[gi]),
      .rise    (sync_rise[gi]),
      .fall    (sync_fall[gi])
    );
  end

  logic le_level, le_rise, le_fall, sclk_rise, sclk_fall, mosi;
  assign le_level  = sync_level[1];
  assign le_rise   = sync_rise[1];
  assign le_fall   = sync_fall[1];
  assign sclk_rise = sync_rise[0];
  assign sclk_fall = sync_fall[0];
  assign mosi      = sync_level[2];

  frame_state_t state_reg, state_next;
  logic [1:0]   flush_cnt_reg;
  logic         flush_done;
  logic         frame_start, frame_end, bit_take, rb_step;

  assign flush_done = (flush_cnt_reg == 2'(SYNC_STAGES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_FLUSH;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (!flush_done) flush_cnt_reg <= flush_cnt_reg + 2'd1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    bit_take    = 1'b0;
    rb_step     = 1'b0;
    case (state_reg)
      ST_FLUSH:  if (flush_done) state_next = le_level ? ST_IDLE : ST_IGNORE;
      ST_IDLE:   if (le_fall) begin
                   state_next  = ST_FRAME;
                   frame_start = 1'b1;
                 end
      ST_FRAME:  if (le_rise) begin
                   state_next = ST_IDLE;
                   frame_end  = 1'b1;
                 end else begin
                   bit_take = sclk_rise;
                   rb_step  = sclk_fall;
                 end
      ST_IGNORE: if (le_rise) state_next = ST_IDLE;
      default:   state_next = ST_FLUSH;
    endcase
  end

  logic [FRAME_BITS-1:0] shift_reg;
  logic [5:0]            bit_cnt_reg;
  logic [DATA_BITS-1:0]  shadow0_reg, shadow1_reg, cfg0_reg, cfg1_reg;
  logic                  cfg_update_reg, frame_ok_reg, frame_err_reg;
  logic                  frame_good;
  logic [3:0]            addr;
  logic [DATA_BITS-1:0]  data;

  assign addr       = shift_reg[3:0];
  assign data       = shift_reg[FRAME_BITS-1:4];
  assign frame_good = frame_end && (bit_cnt_reg == 6'(FRAME_BITS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      shadow0_reg    <= REG0_RST;
      shadow1_reg    <= REG1_RST;
      cfg0_reg       <= REG0_RST;
      cfg1_reg       <= REG1_RST;
      cfg_update_reg <= 1'b0;
      frame_ok_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      cfg_update_reg <= 1'b0;
      frame_ok_reg   <= frame_good;
      frame_err_reg  <= frame_end && !frame_good;
      if (frame_start) begin
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
      end else if (bit_take) begin
        shift_reg <= {mosi, shift_reg[FRAME_BITS-1:1]};
        if (bit_cnt_reg != BIT_CNT_MAX) bit_cnt_reg <= bit_cnt_reg + 6'd1;
      end
      if (frame_good) begin
        case (addr)
          ADDR_REG0:  shadow0_reg <= data;
          ADDR_REG1:  shadow1_reg <= reg1_write(data[25:0]);
          ADDR_APPLY: begin
            cfg0_reg       <= shadow0_reg;
            cfg1_reg       <= shadow1_reg;
            cfg_update_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign shadow0    = shadow0_reg;
  assign shadow1    = shadow1_reg;
  assign cfg0       = cfg0_reg;
  assign cfg1       = cfg1_reg;
  assign cfg_update = cfg_update_reg;
  assign frame_ok   = frame_ok_reg;
  assign frame_err  = frame_err_reg;
  assign in_frame   = (state_reg == ST_FRAME);

`ifdef CDCE_RESP_READBACK_EN
  logic                  armed_reg, sel_reg;
  logic [FRAME_BITS-1:0] rb_shift_reg;
  logic [FRAME_BITS-1:0] rb_word;

  assign rb_word = {sel_reg ? shadow1_reg : shadow0_reg, 3'b000, sel_reg};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_reg    <= 1'b0;
      sel_reg      <= 1'b0;
      rb_shift_reg <= '0;
    end else begin
      // Any frame end consumes the arm; only an accepted read re-arms it.
      if (frame_end) armed_reg <= frame_good && (addr == ADDR_READ);
      if (frame_good && (addr == ADDR_READ)) sel_reg <= data[0];
      if (frame_start)  rb_shift_reg <= rb_word;
      else if (rb_step) rb_shift_reg <= {1'b0, rb_shift_reg[FRAME_BITS-1:1]};
    end
  end

  // Bit 0 appears combinationally in the LE-fall cycle, before the load lands.
  assign spi.spi_miso = armed_reg & (frame_start ? rb_word[0] : (in_frame & rb_shift_reg[0]));

  logic unused_sync;
  assign unused_sync = ^{sync_level[0], sync_rise[2], sync_fall[2]};
`else
  assign spi.spi_miso = 1'b0;

  logic unused_sync;
  assign unused_sync = ^{sync_level[0], sync_rise[2], sync_fall[2], rb_step};
`endif
endmodule

// File: tb/tb_cdce_spi_responder.sv
// Directed bench: frame vector table plus reset, noise and readback sequences.
module tb_cdce_spi_responder;
  logic        clk;
  logic        reset_n;
  logic [27:0] shadow0, shadow1, cfg0, cfg1;
  logic        cfg_update, frame_ok, frame_err, in_frame;

  cdce_spi_responder_if bus ();

  cdce_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi        (bus),
    .shadow0    (shadow0),
    .shadow1    (shadow1),
    .cfg0       (cfg0),
    .cfg1       (cfg1),
    .cfg_update (cfg_update),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .in_frame   (in_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ok_cnt = 0, err_cnt = 0, upd_cnt = 0;
  always @(negedge clk) begin
    if (frame_ok)   ok_cnt++;
    if (frame_err)  err_cnt++;
    if (cfg_update) upd_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0, n_bad = 0;
  logic [31:0] miso_bits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input logic [32:0] word, input int first, input int last);
    for (int i = first; i < last; i++) begin
      bus.spi_mosi = word[i];
      repeat (6) @(negedge clk);
      if (i < 32) miso_bits[i] = bus.spi_miso;
      bus.spi_clk = 1'b1;
      repeat (6) @(negedge clk);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic close_frame();
    repeat (6) @(negedge clk);
    bus.spi_le = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [27:0] d, input int nbits);
    logic [32:0] word;
    word      = {1'b0, d, a};
    miso_bits = '0;
    bus.spi_le = 1'b0;
    shift_bits(word, 0, nbits);
    close_frame();
    $display("frame A=%h D=%h bits=%0d miso=%h shadow0=%h shadow1=%h cfg0=%h cfg1=%h",
             a, d, nbits, miso_bits, shadow0, shadow1, cfg0, cfg1);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [27:0] data;
    int          nbits;
    int          exp_ok;
    int          exp_err;
    int          exp_upd;
    logic [27:0] exp_sh0;
    logic [27:0] exp_sh1;
    logic [27:0] exp_cfg0;
    logic [27:0] exp_cfg1;
    logic [31:0] exp_miso;
  } vec_t;

  vec_t vecs [10];
  logic [31:0] rb_after_read;
  int ok0, err0, upd0;

  initial begin
`ifdef CDCE_RESP_READBACK_EN
    rb_after_read = 32'h0ABCDEF0;
`else
    rb_after_read = 32'h0;
`endif
    vecs[0] = '{4'h0, 28'h0ABCDEF, 32, 1, 0, 0, 28'h0ABCDEF, 28'h8000000, 28'h0000000, 28'h8000000, 32'h0};
    vecs[1] = '{4'hF, 28'h0000000, 32, 1, 0, 1, 28'h0ABCDEF, 28'h8000000, 28'h0ABCDEF, 28'h8000000, 32'h0};
    vecs[2] = '{4'h1, 28'hFFFFFFF, 32, 1, 0, 0, 28'h0ABCDEF, 28'hBFFFFFF, 28'h0ABCDEF, 28'h8000000, 32'h0};
    vecs[3] = '{4'h0, 28'h1111111, 31, 0, 1, 0, 28'h0ABCDEF, 28'hBFFFFFF, 28'h0ABCDEF, 28'h8000000, 32'h0};
    vecs[4] = '{4'h0, 28'h2222222, 33, 0, 1, 0, 28'h0ABCDEF, 28'hBFFFFFF, 28'h0ABCDEF, 28'h8000000, 32'h0};
    vecs[5] = '{4'h5, 28'h1234567, 32, 1, 0, 0, 28'h0ABCDEF, 28'hBFFFFFF, 28'h0ABCDEF, 28'h8000000, 32'h0};
    vecs[6] = '{4'h2, 28'h0000000, 32, 1, 0, 0, 28'h0ABCDEF, 28'hBFFFFFF, 28'h0ABCDEF, 28'h8000000, 32'h0};
    vecs[7] = '{4'h1, 28'h0000001, 32, 1, 0, 0, 28'h0ABCDEF, 28'h8000001, 28'h0ABCDEF, 28'h8000000, rb_after_read};
    vecs[8] = '{4'hF, 28'h0000000, 32, 1, 0, 1, 28'h0ABCDEF, 28'h8000001, 28'h0ABCDEF, 28'h8000001, 32'h0};
    vecs[9] = '{4'h0, 28'h0000000, 32, 1, 0, 0, 28'h0000000, 28'h8000001, 28'h0ABCDEF, 28'h8000001, 32'h0};

    reset_n      = 1'b0;
    bus.spi_clk  = 1'b0;
    bus.spi_le   = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    check("rst_shadow0", shadow0, 28'h0000000);
    check("rst_shadow1", shadow1, 28'h8000000);
    check("rst_cfg0", cfg0, 28'h0000000);
    check("rst_cfg1", cfg1, 28'h8000000);
    check("rst_in_frame", in_frame, 0);
    check("rst_miso", bus.spi_miso, 0);
    check("rst_pulses", ok_cnt + err_cnt + upd_cnt, 0);

    for (int v = 0; v < 10; v++) begin
      ok0 = ok_cnt; err0 = err_cnt; upd0 = upd_cnt;
      send_frame(vecs[v].addr, vecs[v].data, vecs[v].nbits);
      check($sformatf("v%0d_ok", v),   ok_cnt - ok0,   vecs[v].exp_ok);
      check($sformatf("v%0d_err", v),  err_cnt - err0, vecs[v].exp_err);
      check($sformatf("v%0d_upd", v),  upd_cnt - upd0, vecs[v].exp_upd);
      check($sformatf("v%0d_sh0", v),  shadow0, vecs[v].exp_sh0);
      check($sformatf("v%0d_sh1", v),  shadow1, vecs[v].exp_sh1);
      check($sformatf("v%0d_cfg0", v), cfg0, vecs[v].exp_cfg0);
      check($sformatf("v%0d_cfg1", v), cfg1, vecs[v].exp_cfg1);
      check($sformatf("v%0d_miso", v), miso_bits, vecs[v].exp_miso);
      check($sformatf("v%0d_idle", v), in_frame, 0);
    end

    // Readback: register 0 then register 1
    send_frame(4'h0, 28'h1234567, 32);
    send_frame(4'h2, 28'h0000000, 32);
    send_frame(4'h3, 28'h0000000, 32);
`ifdef CDCE_RESP_READBACK_EN
    check("rb_reg0", miso_bits, 32'h12345670);
`else
    check("rb_reg0_off", miso_bits, 32'h0);
`endif
    send_frame(4'h3, 28'h0000000, 32);
    check("rb_disarmed", miso_bits, 32'h0);
    send_frame(4'h2, 28'h0000001, 32);
    send_frame(4'h3, 28'h0000000, 32);
`ifdef CDCE_RESP_READBACK_EN
    check("rb_reg1", miso_bits, 32'h80000011);
`else
    check("rb_reg1_off", miso_bits, 32'h0);
`endif
    check("rb_sh0", shadow0, 28'h1234567);

    // Reset in the middle of a frame, released with LE still low
    ok0 = ok_cnt; err0 = err_cnt; upd0 = upd_cnt;
    miso_bits  = '0;
    bus.spi_le = 1'b0;
    shift_bits({1'b0, 28'hFFFFFFF, 4'h0}, 0, 16);
    check("mid_in_frame", in_frame, 1);
    reset_n = 1'b0;
    #1;
    check("async_sh0", shadow0, 28'h0000000);
    check("async_cfg1", cfg1, 28'h8000000);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    shift_bits({1'b0, 28'hFFFFFFF, 4'h0}, 16, 32);
    close_frame();
    $display("frame reset-split A=0 D=FFFFFFF shadow0=%h", shadow0);
    check("rsplit_ok", ok_cnt - ok0, 0);
    check("rsplit_err", err_cnt - err0, 0);
    check("rsplit_sh0", shadow0, 28'h0000000);
    check("rsplit_sh1", shadow1, 28'h8000000);
    check("rsplit_cfg0", cfg0, 28'h0000000);
    check("rsplit_cfg1", cfg1, 28'h8000000);

    // SPI clock noise with LE high, then one good frame
    ok0 = ok_cnt; err0 = err_cnt;
    for (int i = 0; i < 40; i++) begin
      bus.spi_clk = 1'b1;
      repeat (3) @(negedge clk);
      bus.spi_clk = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("noise_no_frame", ok_cnt + err_cnt - ok0 - err0, 0);
    send_frame(4'h0, 28'h5A5A5A5, 32);
    check("noise_ok", ok_cnt - ok0, 1);
    check("noise_err", err_cnt - err0, 0);
    check("noise_sh0", shadow0, 28'h5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
